// File: rtl/psi_stream_seq.sv
// Streaming private-set-intersection engine. It keeps a running intersection and folds in one
// ascending K-element party set per handshake, using a two-pointer merge that does one comparison per cycle.
module psi_stream_seq #(
  parameter int W     = 16,
  parameter int K     = 10,
  parameter int N_MAX = 32,
  parameter int CW    = $clog2(K + 1),
  parameter int PW    = $clog2(N_MAX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [W*K-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W*K-1:0]  out_data,
  output logic [CW-1:0]   out_count,
  output logic [PW-1:0]   out_parties
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_MERGE,
    S_OUT
  } state_t;

  localparam logic [CW-1:0] K_C       = CW'(K);
  localparam logic [PW-1:0] LAST_PRTY = PW'(N_MAX - 1);

  state_t          state_q;
  logic [W-1:0]    acc_q [K];
  logic [W-1:0]    b_q   [K];
  logic [CW-1:0]   acc_cnt_q;
  logic [CW-1:0]   i_q;
  logic [CW-1:0]   j_q;
  logic [CW-1:0]   k_q;
  logic [PW-1:0]   parties_q;
  logic            last_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [W*K-1:0]  out_data_q;
  logic [CW-1:0]   out_count_q;
  logic [PW-1:0]   out_parties_q;

  logic [W-1:0]    a_cur_d;
  logic [W-1:0]    b_cur_d;
  logic            merge_done_d;
  logic            last_d;
  logic            first_last_d;
  logic [W*K-1:0]  out_acc_d;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    a_cur_d      = '0;
    b_cur_d      = '0;
    merge_done_d = (i_q >= acc_cnt_q) || (j_q >= K_C);
    last_d       = in_last || (parties_q == LAST_PRTY);
    first_last_d = in_last || (N_MAX == 1);
    if (i_q < K_C) a_cur_d = acc_q[i_q];
    if (j_q < K_C) b_cur_d = b_q[j_q];
  end

  // Slots at or past the write pointer still hold stale survivors, so they are zeroed on the way out.
  always_comb begin
    out_acc_d = '0;
    for (int s = 0; s < K; s++) begin
      if (CW'(s) < k_q) out_acc_d[W*s +: W] = acc_q[s];
    end
  end

  // NOTE: the small set arrays are cleared on reset like every other register, so a run that restarts
  // after reset never sees values left over from an aborted merge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      acc_cnt_q     <= '0;
      i_q           <= '0;
      j_q           <= '0;
      k_q           <= '0;
      parties_q     <= '0;
      last_q        <= 1'b0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_count_q   <= '0;
      out_parties_q <= '0;
      for (int e = 0; e < K; e++) begin
        acc_q[e] <= '0;
        b_q[e]   <= '0;
      end
    end else begin
      // NOTE: all state here is updated with non-blocking assignments, so every read sees the pre-edge value.
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            for (int e = 0; e < K; e++) acc_q[e] <= in_data[W*e +: W];
            acc_cnt_q <= K_C;
            parties_q <= PW'(1);
            if (first_last_d) begin
              state_q       <= S_OUT;
              in_ready_q    <= 1'b0;
              out_valid_q   <= 1'b1;
              out_data_q    <= in_data;
              out_count_q   <= K_C;
              out_parties_q <= PW'(1);
            end else begin
              state_q <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (in_valid && in_ready_q) begin
            for (int e = 0; e < K; e++) b_q[e] <= in_data[W*e +: W];
            last_q     <= last_d;
            parties_q  <= parties_q + PW'(1);
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_MERGE;
          end
        end

        S_MERGE: begin
          if (merge_done_d) begin
            acc_cnt_q <= k_q;
            if (last_q) begin
              state_q       <= S_OUT;
              out_valid_q   <= 1'b1;
              out_data_q    <= out_acc_d;
              out_count_q   <= k_q;
              out_parties_q <= parties_q;
            end else begin
              state_q    <= S_WAIT;
              in_ready_q <= 1'b1;
            end
          end else if (a_cur_d == b_cur_d) begin
            // The write index never passes the read index, so compacting in place is safe.
            acc_q[k_q] <= a_cur_d;
            k_q        <= k_q + CW'(1);
            i_q        <= i_q + CW'(1);
            j_q        <= j_q + CW'(1);
          end else if (a_cur_d < b_cur_d) begin
            i_q <= i_q + CW'(1);
          end else begin
            j_q <= j_q + CW'(1);
          end
        end

        S_OUT: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_count   = out_count_q;
  assign out_parties = out_parties_q;

endmodule
